// File: rtl/video_pkg.sv
// video_pkg
//
// Shared definitions for the video pixel-source stages.
//   pattern_e    : test-pattern selector, in display order BARS -> CHECKER ->
//                  GRADIENT -> MOVING -> BARS
//   BAR_COLOUR_* : the eight colour-bar values, {R, G, B}
//   barColour()  : maps a bar index (0 = leftmost) to its colour
package video_pkg;

    typedef enum logic [1:0] {
        PAT_BARS     = 2'd0,
        PAT_CHECKER  = 2'd1,
        PAT_GRADIENT = 2'd2,
        PAT_MOVING   = 2'd3
    } pattern_e;

    localparam logic [23:0] BAR_COLOUR_0 = 24'hFFFFFF;
    localparam logic [23:0] BAR_COLOUR_1 = 24'hFFFF00;
    localparam logic [23:0] BAR_COLOUR_2 = 24'h00FFFF;
    localparam logic [23:0] BAR_COLOUR_3 = 24'h00FF00;
    localparam logic [23:0] BAR_COLOUR_4 = 24'hFF00FF;
    localparam logic [23:0] BAR_COLOUR_5 = 24'hFF0000;
    localparam logic [23:0] BAR_COLOUR_6 = 24'h0000FF;
    localparam logic [23:0] BAR_COLOUR_7 = 24'h000000;

    // Look up the colour of one of the eight vertical bars.
    function automatic logic [23:0] barColour(input logic [2:0] idx);
        logic [23:0] colour;
        colour = BAR_COLOUR_7;
        case (idx)
            3'd0: colour = BAR_COLOUR_0;
            3'd1: colour = BAR_COLOUR_1;
            3'd2: colour = BAR_COLOUR_2;
            3'd3: colour = BAR_COLOUR_3;
            3'd4: colour = BAR_COLOUR_4;
            3'd5: colour = BAR_COLOUR_5;
            3'd6: colour = BAR_COLOUR_6;
            default: colour = BAR_COLOUR_7;
        endcase
        return colour;
    endfunction

endpackage

// File: rtl/pixel_delay.sv
// pixel_delay
//
// Shift register that advances only on pixel strobes, used to carry the
// sync/active bits alongside the RGB pipeline so every output stays aligned.
//   clk_i   : clock
//   rst_n_i : asynchronous active-low reset, clears every stage
//   en_i    : pixel strobe; the register shifts only while it is high
//   data_i  : WIDTH-bit value entering the delay line
//   data_o  : value that entered DEPTH strobes earlier
module pixel_delay #(
    parameter int WIDTH = 3,
    parameter int DEPTH = 2
) (
    input  logic             clk_i,
    input  logic             rst_n_i,
    input  logic             en_i,
    input  logic [WIDTH-1:0] data_i,
    output logic [WIDTH-1:0] data_o
);

    logic [WIDTH-1:0] pipe_q [DEPTH];

    // Each strobe moves every stage one step along; between strobes the
    // whole line holds so the outputs stay steady.
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            for (int i = 0; i < DEPTH; i++) begin
                pipe_q[i] <= '0;
            end
        end else if (en_i) begin
            pipe_q[0] <= data_i;
            for (int i = 1; i < DEPTH; i++) begin
                pipe_q[i] <= pipe_q[i-1];
            end
        end
    end

    assign data_o = pipe_q[DEPTH-1];

endmodule

// File: rtl/pattern_generator.sv
// pattern_generator
//
// Pixel source between the video timing controller and the HDMI transmitter.
// Turns the controller's counters into one of four test patterns and delays
// the syncs through the same two-strobe pipeline as the RGB data.
//   clk_i, rst_n_i          : clock, asynchronous active-low reset
//   pxl_en_i                : pixel strobe, inputs sampled only when high
//   hcount_i, vcount_i      : pixel / line counters from the timing controller
//   hs_i, vs_i, ad_i        : syncs and active-video flag
//   nf_i                    : new-frame marker (frame boundary = pxl_en_i & nf_i)
//   mode_next_i             : request to step to the next pattern at the next boundary
//   rgb_o                   : {R, G, B}, zero outside active video
//   hs_o, vs_o, de_o        : delayed syncs and data enable
//   mode_o                  : pattern currently displayed
// Build option PATTERN_AUTO_CYCLE_EN: also steps the pattern every AUTO_FRAMES frames.
module pattern_generator
    import video_pkg::*;
#(
    parameter int ACTIVE_H_PIXELS = 1280,
    parameter int ACTIVE_LINES    = 720,
    parameter int HCNTR_BITS      = 11,
    parameter int VCNTR_BITS      = 10,
    parameter int CHECK_LOG2      = 5,
    parameter int BAR_W           = 64,
    parameter int BAR_STEP        = 8,
    parameter int AUTO_FRAMES     = 120
) (
    input  logic                  clk_i,
    input  logic                  rst_n_i,
    input  logic                  pxl_en_i,
    input  logic [HCNTR_BITS-1:0] hcount_i,
    input  logic [VCNTR_BITS-1:0] vcount_i,
    input  logic                  hs_i,
    input  logic                  vs_i,
    input  logic                  ad_i,
    input  logic                  nf_i,
    input  logic                  mode_next_i,
    output logic [23:0]           rgb_o,
    output logic                  hs_o,
    output logic                  vs_o,
    output logic                  de_o,
    output logic [1:0]            mode_o
);

    localparam int BAR_PIX = ACTIVE_H_PIXELS / 8;
    localparam int XW      = HCNTR_BITS + 1;

    pattern_e        state_q, state_d;
    logic            pend_q, pend_d;
    logic            advance;
    logic            autoWrap;
    logic            frameBoundary;
    logic [XW-1:0]   barX_q, barX_d;
    logic [XW-1:0]   barSum;
    logic [XW-1:0]   hcountX;
    logic [2:0]      barIdx;
    logic            inBar;

    pattern_e        mode1_q;
    logic [2:0]      barIdx1_q;
    logic            checker1_q;
    logic            inBar1_q;
    logic [7:0]      hcnt1_q;
    logic [7:0]      vcnt1_q;
    logic [23:0]     pixel;
    logic [23:0]     rgb_q;
    logic [2:0]      syncDly;

    assign frameBoundary = pxl_en_i & nf_i;

`ifdef PATTERN_AUTO_CYCLE_EN
    localparam int FC_W = (AUTO_FRAMES > 1) ? $clog2(AUTO_FRAMES) : 1;
    logic [FC_W-1:0] frameCnt_q;

    assign autoWrap = (frameCnt_q == FC_W'(AUTO_FRAMES - 1));

    // Frame counter restarts on every pattern change, manual or automatic,
    // so a manual step always buys a full AUTO_FRAMES of the new pattern.
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            frameCnt_q <= '0;
        end else if (frameBoundary) begin
            frameCnt_q <= advance ? '0 : frameCnt_q + 1'b1;
        end
    end

    logic unusedCfg;
    assign unusedCfg = ^{vcount_i, 1'(ACTIVE_LINES)};
`else
    assign autoWrap = 1'b0;

    logic unusedCfg;
    assign unusedCfg = ^{vcount_i, 1'(ACTIVE_LINES), 1'(AUTO_FRAMES)};
`endif

    // Pattern state register and the sticky request flag.
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            state_q <= PAT_BARS;
            pend_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            pend_q  <= pend_d;
        end
    end

    // Requests are collapsed into one pending step that fires at the frame
    // boundary; a request landing on the boundary itself is honoured there.
    // The automatic wrap merges with a manual request into a single step.
    always_comb begin
        state_d = state_q;
        pend_d  = pend_q;
        advance = 1'b0;
        if (frameBoundary) begin
            advance = pend_q | mode_next_i | autoWrap;
            pend_d  = 1'b0;
        end else if (mode_next_i) begin
            pend_d = 1'b1;
        end
        if (advance) begin
            case (state_q)
                PAT_BARS:     state_d = PAT_CHECKER;
                PAT_CHECKER:  state_d = PAT_GRADIENT;
                PAT_GRADIENT: state_d = PAT_MOVING;
                default:      state_d = PAT_BARS;
            endcase
        end
    end

    assign mode_o = state_q;

    // Moving-bar position steps every frame, whatever pattern is shown,
    // and wraps back into the active line rather than running off it.
    assign barSum = barX_q + XW'(BAR_STEP);
    always_comb begin
        barX_d = barX_q;
        if (frameBoundary) begin
            barX_d = (barSum >= XW'(ACTIVE_H_PIXELS)) ? barSum - XW'(ACTIVE_H_PIXELS) : barSum;
        end
    end

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            barX_q <= '0;
        end else begin
            barX_q <= barX_d;
        end
    end

    // Bar index from a comparator chain: the lowest boundary the pixel sits
    // below wins, anything beyond the seventh boundary lands in bar 7.
    always_comb begin
        barIdx = 3'd7;
        for (int i = 6; i >= 0; i--) begin
            if (hcount_i < HCNTR_BITS'((i + 1) * BAR_PIX)) begin
                barIdx = 3'(i);
            end
        end
    end

    // The bar end is never folded back to the left, so a bar near the right
    // edge is simply clipped by the end of active video.
    assign hcountX = {1'b0, hcount_i};
    assign inBar   = (hcountX >= barX_q) && (hcountX < barX_q + XW'(BAR_W));

    // Stage 1: register the per-pattern decode together with the pattern in
    // force for this pixel.
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            mode1_q    <= PAT_BARS;
            barIdx1_q  <= '0;
            checker1_q <= 1'b0;
            inBar1_q   <= 1'b0;
            hcnt1_q    <= '0;
            vcnt1_q    <= '0;
        end else if (pxl_en_i) begin
            mode1_q    <= state_q;
            barIdx1_q  <= barIdx;
            checker1_q <= hcount_i[CHECK_LOG2] ^ vcount_i[CHECK_LOG2];
            inBar1_q   <= inBar;
            hcnt1_q    <= hcount_i[7:0];
            vcnt1_q    <= vcount_i[7:0];
        end
    end

    // Colour selection from the stage-1 decode.
    always_comb begin
        pixel = '0;
        case (mode1_q)
            PAT_BARS:     pixel = barColour(barIdx1_q);
            PAT_CHECKER:  pixel = checker1_q ? 24'hFFFFFF : 24'h000000;
            PAT_GRADIENT: pixel = {hcnt1_q, vcnt1_q, 8'h80};
            default:      pixel = inBar1_q ? 24'hFFFFFF : 24'h000040;
        endcase
    end

    // Stage 2: the RGB register.
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            rgb_q <= '0;
        end else if (pxl_en_i) begin
            rgb_q <= pixel;
        end
    end

    pixel_delay #(
        .WIDTH (3),
        .DEPTH (2)
    ) u_syncDelay (
        .clk_i   (clk_i),
        .rst_n_i (rst_n_i),
        .en_i    (pxl_en_i),
        .data_i  ({hs_i, vs_i, ad_i}),
        .data_o  (syncDly)
    );

    assign hs_o  = syncDly[2];
    assign vs_o  = syncDly[1];
    assign de_o  = syncDly[0];
    assign rgb_o = de_o ? rgb_q : 24'h000000;

endmodule

// File: tb/tb_pattern_generator.sv
// tb_pattern_generator
//
// Directed bench for pattern_generator. Every expected value below is worked
// out by hand from the pattern definitions; the bench only tracks how many
// frame boundaries it has issued so it knows where the moving bar sits.
module tb_pattern_generator;

`ifdef PATTERN_AUTO_CYCLE_EN
    localparam int AUTO_N = 4;
`else
    localparam int AUTO_N = 120;
`endif

    logic        clk_i = 1'b0;
    logic        rst_n_i = 1'b0;
    logic        pxl_en_i = 1'b0;
    logic [10:0] hcount_i = '0;
    logic [9:0]  vcount_i = '0;
    logic        hs_i = 1'b0;
    logic        vs_i = 1'b0;
    logic        ad_i = 1'b0;
    logic        nf_i = 1'b0;
    logic        mode_next_i = 1'b0;
    logic [23:0] rgb_o;
    logic        hs_o, vs_o, de_o;
    logic [1:0]  mode_o;

    int compared = 0;
    int mismatched = 0;

    pattern_generator #(
        .ACTIVE_H_PIXELS (1280),
        .ACTIVE_LINES    (720),
        .HCNTR_BITS      (11),
        .VCNTR_BITS      (10),
        .CHECK_LOG2      (5),
        .BAR_W           (64),
        .BAR_STEP        (8),
        .AUTO_FRAMES     (AUTO_N)
    ) dut (
        .clk_i       (clk_i),
        .rst_n_i     (rst_n_i),
        .pxl_en_i    (pxl_en_i),
        .hcount_i    (hcount_i),
        .vcount_i    (vcount_i),
        .hs_i        (hs_i),
        .vs_i        (vs_i),
        .ad_i        (ad_i),
        .nf_i        (nf_i),
        .mode_next_i (mode_next_i),
        .rgb_o       (rgb_o),
        .hs_o        (hs_o),
        .vs_o        (vs_o),
        .de_o        (de_o),
        .mode_o      (mode_o)
    );

    always #5 clk_i = ~clk_i;

    // Compare one observed value with its hand-computed expectation.
    task automatic checkOutput(input string tag, input logic [23:0] actual, input logic [23:0] expected);
        compared++;
        if (actual !== expected) begin
            mismatched++;
            $display("[TB] FAIL %s: got %h, expected %h", tag, actual, expected);
        end
    endtask

    // One pixel strobe with the given inputs; outputs are settled 1ns after the edge.
    task automatic applyStimulus(input logic [10:0] h, input logic [9:0] v, input logic hs,
                                 input logic vs, input logic ad, input logic nf, input logic mnext);
        @(negedge clk_i);
        hcount_i    = h;
        vcount_i    = v;
        hs_i        = hs;
        vs_i        = vs;
        ad_i        = ad;
        nf_i        = nf;
        mode_next_i = mnext;
        pxl_en_i    = 1'b1;
        @(posedge clk_i);
        #1;
        pxl_en_i    = 1'b0;
        nf_i        = 1'b0;
        mode_next_i = 1'b0;
    endtask

    // Active pixel followed by one blank strobe, so the pixel is at the outputs.
    task automatic pushPixel(input logic [10:0] h, input logic [9:0] v);
        applyStimulus(h, v, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
        applyStimulus(11'd0, 10'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    endtask

    // Frame-boundary strobe, optionally with a coinciding pattern request.
    task automatic boundary(input logic mnext);
        applyStimulus(11'd1280, 10'd720, 1'b0, 1'b0, 1'b0, 1'b1, mnext);
    endtask

    // Pattern request outside any strobe.
    task automatic pulseNext();
        @(negedge clk_i);
        mode_next_i = 1'b1;
        @(posedge clk_i);
        #1;
        mode_next_i = 1'b0;
    endtask

    initial begin
        $display("[TB] starting pattern_generator bench");
        repeat (3) @(posedge clk_i);
        #1;
        checkOutput("reset_rgb",  rgb_o,        24'h0);
        checkOutput("reset_hs",   24'(hs_o),    24'h0);
        checkOutput("reset_vs",   24'(vs_o),    24'h0);
        checkOutput("reset_de",   24'(de_o),    24'h0);
        checkOutput("reset_mode", 24'(mode_o),  24'h0);
        @(negedge clk_i);
        rst_n_i = 1'b1;

        // First pixel after reset, BARS pattern.
        applyStimulus(11'd0, 10'd0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
        checkOutput("lat1_de", 24'(de_o), 24'h0);
        applyStimulus(11'd0, 10'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        checkOutput("first_rgb",  rgb_o,       24'hFFFFFF);
        checkOutput("first_de",   24'(de_o),   24'h1);
        checkOutput("first_mode", 24'(mode_o), 24'h0);

        pushPixel(11'd159, 10'd0);
        checkOutput("bars_159", rgb_o, 24'hFFFFFF);
        pushPixel(11'd160, 10'd0);
        checkOutput("bars_160", rgb_o, 24'hFFFF00);
        pushPixel(11'd480, 10'd0);
        checkOutput("bars_480", rgb_o, 24'h00FF00);
        pushPixel(11'd1279, 10'd0);
        checkOutput("bars_1279", rgb_o, 24'h000000);

        // Sync latency, including idle clocks between strobes.
        applyStimulus(11'd0, 10'd0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        checkOutput("hs_early", 24'(hs_o), 24'h0);
        repeat (5) @(posedge clk_i);
        #1;
        checkOutput("hs_idle", 24'(hs_o), 24'h0);
        applyStimulus(11'd0, 10'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        checkOutput("hs_out",    24'(hs_o), 24'h1);
        checkOutput("hs_vs_out", 24'(vs_o), 24'h0);
        checkOutput("hs_de_out", 24'(de_o), 24'h0);
        checkOutput("hs_rgb",    rgb_o,     24'h0);
        applyStimulus(11'd0, 10'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        checkOutput("hs_clear", 24'(hs_o), 24'h0);

`ifdef PATTERN_AUTO_CYCLE_EN
        // Automatic cycling every 4 frames; a request on the wrap boundary merges.
        for (int i = 0; i < 3; i++) boundary(1'b0);
        checkOutput("auto_3", 24'(mode_o), 24'h0);
        boundary(1'b0);
        checkOutput("auto_4", 24'(mode_o), 24'h1);
        for (int i = 0; i < 3; i++) boundary(1'b0);
        checkOutput("auto_7", 24'(mode_o), 24'h1);
        boundary(1'b1);
        checkOutput("auto_8_merge", 24'(mode_o), 24'h2);
`else
        // Several requests in one frame give exactly one step.
        pulseNext();
        pulseNext();
        pulseNext();
        checkOutput("pend_hold", 24'(mode_o), 24'h0);
        boundary(1'b0);                                    // boundary 1, bar_x 8
        checkOutput("mode_step1", 24'(mode_o), 24'h1);
        boundary(1'b0);                                    // boundary 2, bar_x 16
        checkOutput("mode_nostep", 24'(mode_o), 24'h1);
        pushPixel(11'd32, 10'd0);
        checkOutput("chk_32_0", rgb_o, 24'hFFFFFF);
        pushPixel(11'd32, 10'd32);
        checkOutput("chk_32_32", rgb_o, 24'h000000);

        boundary(1'b1);                                    // boundary 3, bar_x 24
        checkOutput("mode_coincide", 24'(mode_o), 24'h2);
        pushPixel(11'd300, 10'd500);
        checkOutput("grad_300_500", rgb_o, 24'h2CF480);

        pulseNext();
        boundary(1'b0);                                    // boundary 4, bar_x 32
        checkOutput("mode_moving", 24'(mode_o), 24'h3);
        pushPixel(11'd31, 10'd0);
        checkOutput("mov32_31", rgb_o, 24'h000040);
        pushPixel(11'd32, 10'd0);
        checkOutput("mov32_32", rgb_o, 24'hFFFFFF);
        pushPixel(11'd95, 10'd0);
        checkOutput("mov32_95", rgb_o, 24'hFFFFFF);
        pushPixel(11'd96, 10'd0);
        checkOutput("mov32_96", rgb_o, 24'h000040);

        for (int i = 0; i < 155; i++) boundary(1'b0);      // boundary 159, bar_x 1272
        checkOutput("mode_still", 24'(mode_o), 24'h3);
        pushPixel(11'd1279, 10'd0);
        checkOutput("mov1272_1279", rgb_o, 24'hFFFFFF);
        pushPixel(11'd1271, 10'd0);
        checkOutput("mov1272_1271", rgb_o, 24'h000040);
        pushPixel(11'd10, 10'd0);
        checkOutput("mov1272_nowrap", rgb_o, 24'h000040);

        boundary(1'b0);                                    // boundary 160, bar_x 0
        pushPixel(11'd10, 10'd0);
        checkOutput("mov0_10", rgb_o, 24'hFFFFFF);
        pushPixel(11'd70, 10'd0);
        checkOutput("mov0_70", rgb_o, 24'h000040);

        pulseNext();
        boundary(1'b0);
        checkOutput("mode_wrap", 24'(mode_o), 24'h0);
        pushPixel(11'd640, 10'd0);
        checkOutput("bars_640", rgb_o, 24'hFF00FF);
`endif

        // Reset in the middle of a frame clears outputs straight away.
        applyStimulus(11'd0, 10'd0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0);
        applyStimulus(11'd0, 10'd0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0);
        @(negedge clk_i);
        rst_n_i = 1'b0;
        #1;
        checkOutput("midrst_de",   24'(de_o),   24'h0);
        checkOutput("midrst_hs",   24'(hs_o),   24'h0);
        checkOutput("midrst_mode", 24'(mode_o), 24'h0);
        @(negedge clk_i);
        rst_n_i = 1'b1;

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
